psw_unit: RTL and testbench

Owns the processor status word consumed by the EX-stage branch evaluator. Captures ALU flags at EX completion under per-flag write enables, maintains the interrupt-enable bit, and saves/restores the full PSW on interrupt entry and RTI through a small LIFO shadow stack. It is the producer end of the PSW/condition-code interface: branch logic reads `PSW` and never writes it.

---
 rtl/psw_pkg.sv | 19 +
 rtl/psw_stack.sv | 61 ++++++
 rtl/psw_unit.sv | 110 +++++++++++
 tb/tb_psw_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/psw_pkg.sv
// Shared processor-status-word definitions used by the PSW owner and the branch evaluator.
package psw_pkg;

    localparam int unsigned PSW_Z  = 0;
    localparam int unsigned PSW_N  = 1;
    localparam int unsigned PSW_V  = 2;
    localparam int unsigned PSW_IE = 3;
    localparam int unsigned PSW_W  = 4;

    localparam logic [PSW_W-1:0] PSW_RST = 4'b0000;

    typedef struct packed {
        logic ie;
        logic v;
        logic n;
        logic z;
    } psw_t;

endpackage

// File: rtl/psw_stack.sv
// Parameterized LIFO for saved PSW contexts; overflow/underflow requests are silently ignored.
module psw_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] depth_q, depth_d, top;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !push && !empty_q;
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end
        top = depth_q - DW'(1);
    end

    // Storage needs no reset: only slots below depth are ever read meaningfully.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[AW'(depth_q)] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            depth_q <= depth_d;
            full_q  <= (depth_d == DW'(DEPTH));
            empty_q <= (depth_d == '0);
        end
    end

    assign dout  = mem[AW'(top)];
    assign depth = depth_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/psw_unit.sv
// Processor status word owner: flag capture, interrupt-enable control and
// save/restore of the PSW across interrupt entry and RTI.
module psw_unit
    import psw_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               zr_EX,
    input  logic                               neg_EX,
    input  logic                               ov_EX,
    input  logic [2:0]                         flag_upd_EX,
    input  logic                               ei_EX,
    input  logic                               di_EX,
    input  logic                               rti_EX,
    input  logic                               stall_EX,
    input  logic                               flush_EX,
    input  logic                               int_ack,
    output logic [3:0]                         PSW,
    output logic                               int_en,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stk_full,
    output logic                               stk_empty,
    output logic                               psw_err
);

    localparam int unsigned FLAG_W = PSW_W - 1;

    psw_t              psw_q, psw_d;
    logic              err_q, err_d;
    logic              cmd_valid, ei_v, di_v, rti_v;
    logic [FLAG_W-1:0] alu_flags, cur_flags, next_flags;
    logic              next_ie;
    logic              push, pop;
    psw_t              push_val;
    logic [PSW_W-1:0]  stk_dout;

    // Next-state: int_ack beats a valid rti, which beats the ordinary update.
    always_comb begin
        cmd_valid = !stall_EX && !flush_EX;
        ei_v      = cmd_valid && ei_EX;
        di_v      = cmd_valid && di_EX;
        rti_v     = cmd_valid && rti_EX;
        alu_flags = {ov_EX, neg_EX, zr_EX};
        cur_flags = {psw_q.v, psw_q.n, psw_q.z};
        for (int i = 0; i < int'(FLAG_W); i++) begin
            next_flags[i] = (cmd_valid && flag_upd_EX[i]) ? alu_flags[i] : cur_flags[i];
        end

        next_ie = psw_q.ie;
        if (ei_v && !di_v) begin
            next_ie = 1'b1;
        end else if (di_v && !ei_v) begin
            next_ie = 1'b0;
        end

        psw_d    = psw_t'({next_ie, next_flags});
        push_val = psw_t'({psw_q.ie, next_flags});
        push     = 1'b0;
        pop      = 1'b0;
        err_d    = ei_v && di_v;

        if (int_ack) begin
            psw_d = psw_t'({1'b0, next_flags});
            push  = !stk_full;
            if (stk_full || rti_v) begin
                err_d = 1'b1;
            end
        end else if (rti_v) begin
            if (stk_empty) begin
                psw_d = psw_t'({1'b1, cur_flags});
                err_d = 1'b1;
            end else begin
                psw_d = psw_t'(stk_dout);
                pop   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psw_q <= psw_t'(PSW_RST);
            err_q <= 1'b0;
        end else begin
            psw_q <= psw_d;
            err_q <= err_d;
        end
    end

    psw_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PSW_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_val),
        .dout  (stk_dout),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign PSW     = psw_q;
    assign int_en  = psw_q.ie;
    assign psw_err = err_q;

endmodule

// File: tb/tb_psw_unit.sv
// Directed bench for psw_unit: vector table for single-cycle behaviour plus
// hand-written nesting, back-to-back and mid-sequence reset sequences.
module tb_psw_unit;

    logic       clk;
    logic       rst_n;
    logic       zr_EX, neg_EX, ov_EX;
    logic [2:0] flag_upd_EX;
    logic       ei_EX, di_EX, rti_EX, stall_EX, flush_EX, int_ack;
    logic [3:0] PSW;
    logic       int_en;
    logic [2:0] depth;
    logic       stk_full, stk_empty, psw_err;

    int checks   = 0;
    int failures = 0;

    psw_unit #(.STACK_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .zr_EX       (zr_EX),
        .neg_EX      (neg_EX),
        .ov_EX       (ov_EX),
        .flag_upd_EX (flag_upd_EX),
        .ei_EX       (ei_EX),
        .di_EX       (di_EX),
        .rti_EX      (rti_EX),
        .stall_EX    (stall_EX),
        .flush_EX    (flush_EX),
        .int_ack     (int_ack),
        .PSW         (PSW),
        .int_en      (int_en),
        .depth       (depth),
        .stk_full    (stk_full),
        .stk_empty   (stk_empty),
        .psw_err     (psw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: {ei, di, rti, stall, flush, ack}; alu bit order: {V, N, Z}
    typedef struct {
        logic [2:0] alu;
        logic [2:0] upd;
        logic [5:0] ctl;
        logic [3:0] psw;
        logic [2:0] dep;
        logic       err;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [2:0] alu, input logic [2:0] upd, input logic [5:0] ctl,
                                input logic [3:0] psw, input logic [2:0] dep, input logic err);
        vec_t v;
        v.alu = alu; v.upd = upd; v.ctl = ctl; v.psw = psw; v.dep = dep; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_psw, input logic [2:0] e_dep, input logic e_err);
        chk({tag, ".psw"},    32'(PSW),       32'(e_psw));
        chk({tag, ".int_en"}, 32'(int_en),    32'(e_psw[3]));
        chk({tag, ".depth"},  32'(depth),     32'(e_dep));
        chk({tag, ".full"},   32'(stk_full),  32'(e_dep == 3'd4));
        chk({tag, ".empty"},  32'(stk_empty), 32'(e_dep == 3'd0));
        chk({tag, ".err"},    32'(psw_err),   32'(e_err));
    endtask

    // Drive one EX cycle, then sample 1 ns after the capturing edge.
    task automatic step(input logic [2:0] alu, input logic [2:0] upd, input logic [5:0] ctl);
        {ov_EX, neg_EX, zr_EX} = alu;
        flag_upd_EX = upd;
        {ei_EX, di_EX, rti_EX, stall_EX, flush_EX, int_ack} = ctl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_EI    = 6'b100000;
    localparam logic [5:0] C_RTI   = 6'b001000;
    localparam logic [5:0] C_ACK   = 6'b000001;

    logic [3:0] ctx_exp [4];
    logic [2:0] nest_flags [5];

    initial begin
        vecs[0]  = mk(3'b101, 3'b111, 6'b000000, 4'b0101, 3'd0, 1'b0);
        vecs[1]  = mk(3'b010, 3'b010, 6'b000000, 4'b0111, 3'd0, 1'b0);
        vecs[2]  = mk(3'b000, 3'b111, 6'b000100, 4'b0111, 3'd0, 1'b0);
        vecs[3]  = mk(3'b000, 3'b111, 6'b000010, 4'b0111, 3'd0, 1'b0);
        vecs[4]  = mk(3'b000, 3'b000, 6'b100010, 4'b0111, 3'd0, 1'b0);
        vecs[5]  = mk(3'b000, 3'b111, 6'b000000, 4'b0000, 3'd0, 1'b0);
        vecs[6]  = mk(3'b000, 3'b000, 6'b100000, 4'b1000, 3'd0, 1'b0);
        vecs[7]  = mk(3'b001, 3'b001, 6'b000001, 4'b0001, 3'd1, 1'b0);
        vecs[8]  = mk(3'b000, 3'b000, 6'b001000, 4'b1001, 3'd0, 1'b0);
        vecs[9]  = mk(3'b000, 3'b000, 6'b001001, 4'b0001, 3'd1, 1'b1);
        vecs[10] = mk(3'b000, 3'b000, 6'b000000, 4'b0001, 3'd1, 1'b0);
        vecs[11] = mk(3'b000, 3'b000, 6'b110000, 4'b0001, 3'd1, 1'b1);
        vecs[12] = mk(3'b000, 3'b000, 6'b001000, 4'b1001, 3'd0, 1'b0);
        vecs[13] = mk(3'b000, 3'b000, 6'b010000, 4'b0001, 3'd0, 1'b0);
        vecs[14] = mk(3'b000, 3'b000, 6'b001000, 4'b1001, 3'd0, 1'b1);
        vecs[15] = mk(3'b000, 3'b000, 6'b001100, 4'b1001, 3'd0, 1'b0);
        vecs[16] = mk(3'b110, 3'b111, 6'b000101, 4'b0001, 3'd1, 1'b0);
        vecs[17] = mk(3'b000, 3'b000, 6'b001000, 4'b1001, 3'd0, 1'b0);

        nest_flags[0] = 3'b001; nest_flags[1] = 3'b010; nest_flags[2] = 3'b100;
        nest_flags[3] = 3'b011; nest_flags[4] = 3'b111;
        ctx_exp[0] = 4'b1001; ctx_exp[1] = 4'b1010; ctx_exp[2] = 4'b0100; ctx_exp[3] = 4'b1011;

        rst_n = 1'b0;
        {ov_EX, neg_EX, zr_EX} = 3'b000;
        flag_upd_EX = 3'b000;
        {ei_EX, di_EX, rti_EX, stall_EX, flush_EX, int_ack} = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 3'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].alu, vecs[i].upd, vecs[i].ctl);
            chk_all($sformatf("vec%0d", i), vecs[i].psw, vecs[i].dep, vecs[i].err);
        end

        // Five nested interrupts into a 4-deep stack; ei before odd entries varies the saved IE.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 1) begin
                step(3'b000, 3'b000, C_EI);
                chk_all($sformatf("nest_ei%0d", i), {1'b1, nest_flags[i-1]}, 3'(i), 1'b0);
            end
            step(nest_flags[i], 3'b111, C_ACK);
            chk_all($sformatf("nest_ack%0d", i), {1'b0, nest_flags[i]}, (i < 4) ? 3'(i + 1) : 3'd4, i == 4);
        end
        for (int i = 3; i >= 0; i--) begin
            step(3'b000, 3'b000, C_RTI);
            chk_all($sformatf("unnest_rti%0d", i), ctx_exp[i], 3'(i), 1'b0);
        end
        step(3'b000, 3'b000, C_RTI);
        chk_all("underflow_rti", 4'b1001, 3'd0, 1'b1);
        step(3'b000, 3'b000, C_NONE);
        chk_all("err_clears", 4'b1001, 3'd0, 1'b0);

        // Back-to-back int_ack, rti, int_ack.
        step(3'b000, 3'b000, C_ACK);
        chk_all("b2b_ack0", 4'b0001, 3'd1, 1'b0);
        step(3'b000, 3'b000, C_RTI);
        chk_all("b2b_rti", 4'b1001, 3'd0, 1'b0);
        step(3'b000, 3'b000, C_ACK);
        chk_all("b2b_ack1", 4'b0001, 3'd1, 1'b0);

        // Build depth 3, then assert reset mid-cycle.
        step(3'b000, 3'b000, C_ACK);
        step(3'b010, 3'b010, C_ACK);
        chk_all("pre_reset", 4'b0011, 3'd3, 1'b0);
        step(3'b000, 3'b000, C_NONE);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'b000, 3'b000, C_RTI);
        chk_all("post_reset_rti", 4'b1000, 3'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
